// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared constants and helpers for the pipelined adder.
//   DEFAULT_WIDTH  : default operand/sum width in bits
//   DEFAULT_STAGES : default number of pipeline stages
//   chunk_width()  : bits added per stage (WIDTH / STAGES)
//   params_legal() : true when 1 <= STAGES <= WIDTH and STAGES divides WIDTH
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    // Guarded against STAGES=0 so an illegal configuration reaches the
    // elaboration check instead of failing on a divide by zero.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// -----------------------------------------------------------------------------
// pipe_adder_stage
// One pipeline stage: adds chunk IDX (CW bits, LSB-first numbering) of the
// operands with the incoming carry and registers the result together with the
// full operands and the partially built sum.
//   clk, rst         : clock, asynchronous active-high reset
//   load             : stage register may capture this cycle (empty or draining)
//   up_valid         : upstream holds a valid operand set
//   a_in, b_in       : operands travelling down the pipe
//   sum_in, c_in     : lower sum bits and carry produced by earlier stages
//   valid            : this stage holds a valid entry
//   a_q, b_q         : registered operands
//   sum_q, c_q       : registered sum (chunks 0..IDX filled) and chunk carry-out
// -----------------------------------------------------------------------------
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = chunk_width(DEFAULT_WIDTH, DEFAULT_STAGES),
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             c_in,
    output logic             valid,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_q
);

    localparam int LO = IDX * CW;

    logic [CW:0]      chunk;
    logic [WIDTH-1:0] sum_d;

    // NOTE: every variable gets a full default before any partial update, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        chunk = {1'b0, a_in[LO +: CW]} + {1'b0, b_in[LO +: CW]} + {{CW{1'b0}}, c_in};
        sum_d = sum_in;
        sum_d[LO +: CW] = chunk[CW-1:0];
    end

    // NOTE: the data registers are reset along with the valid bit so the
    // visible sum/cout/ovf read zero during reset, not just out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its upstream's pre-edge value.
            valid <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
        end else if (load) begin
            // An empty upstream loads a bubble; data is left as-is since it
            // is never observed without its valid bit.
            valid <= up_valid;
            if (up_valid) begin
                a_q   <= a_in;
                b_q   <= b_in;
                sum_q <= sum_d;
                c_q   <= chunk[CW];
            end
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Valid/ready pipelined adder: sum = (a + b + cin) mod 2^WIDTH, cout = carry
// out of bit WIDTH-1. The add is split into STAGES chunks of WIDTH/STAGES bits,
// one chunk per stage, LSB first. Latency STAGES cycles, one result per cycle,
// per-stage bubble collapse.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake
//   a, b, cin            : unsigned operands and carry-in
//   out_valid, out_ready : result handshake
//   sum, cout            : result
//   ovf                  : signed overflow flag, present only when the macro
//                          PIPE_ADDER_OVF_EN is defined
// -----------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_illegal_params
        $error("pipe_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    // Index 0 is the block input; index k+1 is the output of stage k.
    logic             valid_p [STAGES+1];
    logic [WIDTH-1:0] a_p     [STAGES+1];
    logic [WIDTH-1:0] b_p     [STAGES+1];
    logic [WIDTH-1:0] sum_p   [STAGES+1];
    logic             c_p     [STAGES+1];

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_load;

    // A stage may load when it is empty or when its downstream takes its
    // entry this cycle; the chain starts at out_ready and never sees in_valid.
    function automatic logic [STAGES-1:0] load_chain(input logic [STAGES-1:0] v,
                                                     input logic              down_ready);
        logic [STAGES-1:0] ld;
        ld = '0;
        ld[STAGES-1] = !v[STAGES-1] || down_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !v[k] || ld[k+1];
        end
        return ld;
    endfunction

    always_comb begin
        stage_load = load_chain(stage_valid, out_ready);
    end

    assign in_ready   = stage_load[0];

    assign valid_p[0] = in_valid;
    assign a_p[0]     = a;
    assign b_p[0]     = b;
    assign sum_p[0]   = '0;
    assign c_p[0]     = cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .load     (stage_load[k]),
            .up_valid (valid_p[k]),
            .a_in     (a_p[k]),
            .b_in     (b_p[k]),
            .sum_in   (sum_p[k]),
            .c_in     (c_p[k]),
            .valid    (valid_p[k+1]),
            .a_q      (a_p[k+1]),
            .b_q      (b_p[k+1]),
            .sum_q    (sum_p[k+1]),
            .c_q      (c_p[k+1])
        );
        assign stage_valid[k] = valid_p[k+1];
    end

    assign out_valid = valid_p[STAGES];
    assign sum       = sum_p[STAGES];
    assign cout      = c_p[STAGES];

    // The final operands are only needed for the overflow sign test.
    logic unused_final_operands;
    assign unused_final_operands = ^{a_p[STAGES], b_p[STAGES]};

`ifdef PIPE_ADDER_OVF_EN
    // Same-sign operands whose sum has the opposite sign overflowed.
    assign ovf = (a_p[STAGES][WIDTH-1] == b_p[STAGES][WIDTH-1]) &&
                 (sum_p[STAGES][WIDTH-1] != a_p[STAGES][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder. Three instances share clk/rst:
//   8-bit / 2 stages (main), 16-bit / 4 stages, 1-bit / 1 stage.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Define PIPE_ADDER_OVF_EN to exercise the ovf port as well.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 8-bit, 2-stage instance
    logic       in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [7:0] a, b, sum;
    // 16-bit, 4-stage instance
    logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_out_ready, w_cout;
    logic [15:0] w_a, w_b, w_sum;
    // 1-bit, 1-stage instance
    logic s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout;
    logic s_a, s_b, s_sum;
`ifdef PIPE_ADDER_OVF_EN
    logic ovf, w_ovf, s_ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } res_t;

    res_t exp_q[$];

    pipe_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(w_ovf)
`endif
    );

    pipe_adder #(.WIDTH(1), .STAGES(1)) dut_single (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(s_ovf)
`endif
    );

    // Reference: plain integer arithmetic, unsigned for sum/cout and signed
    // range test for overflow.
    function automatic res_t model8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        res_t r;
        int   u;
        int   sv;
        u   = int'(x) + int'(y) + int'(ci);
        sv  = int'($signed(x)) + int'($signed(y)) + int'(ci);
        r.s = u[7:0];
        r.c = (u > 255);
        r.o = (sv > 127) || (sv < -128);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({out_valid, sum, cout} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b, want all 0", out_valid, sum, cout);
        end
`ifdef PIPE_ADDER_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_carry_latency();
        @(negedge clk);
        a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_accept: in_ready got %b want 1", in_ready);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_cmp++;
            if (c == 2) begin
                if ({out_valid, sum, cout} !== {1'b1, 8'h00, 1'b1}) begin
                    n_bad++;
                    $display("FAIL carry_result: got valid=%b sum=%h cout=%b want 1/00/1", out_valid, sum, cout);
                end
            end else if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL carry_latency cycle %0d: out_valid got %b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op_a [4] = '{8'h00, 8'h0F, 8'hF0, 8'hAA};
        logic [7:0] op_b [4] = '{8'h00, 8'h01, 8'h10, 8'h55};
        logic       op_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] want [4] = '{{8'h00, 1'b0}, {8'h10, 1'b0}, {8'h00, 1'b1}, {8'h00, 1'b1}};
        out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                a = op_a[c]; b = op_b[c]; cin = op_c[c]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 4) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_in_ready cycle %0d: got %b want 1", c, in_ready);
                end
            end
            n_cmp++;
            if (c >= 2 && c < 6) begin
                if ({out_valid, sum, cout} !== {1'b1, want[c-2]}) begin
                    n_bad++;
                    $display("FAIL b2b_result %0d: got valid=%b sum=%h cout=%b want 1/%h/%b",
                             c - 2, out_valid, sum, cout, want[c-2][8:1], want[c-2][0]);
                end
            end else if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_idle cycle %0d: out_valid got %b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        res_t rx, ry;
        rx = model8(8'h12, 8'h34, 1'b0);
        ry = model8(8'h80, 8'h90, 1'b1);
        out_ready = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            case (c)
                0: begin a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1; end
                1: begin a = 8'h80; b = 8'h90; cin = 1'b1; in_valid = 1'b1; end
                2: begin a = 8'h55; b = 8'h66; cin = 1'b0; in_valid = 1'b1; end
                6: begin in_valid = 1'b0; out_ready = 1'b1; end
                default: ;
            endcase
            #1;
            n_cmp++;
            if (in_ready !== ((c < 2) || (c >= 6))) begin
                n_bad++;
                $display("FAIL stall_in_ready cycle %0d: got %b want %b", c, in_ready, (c < 2) || (c >= 6));
            end
            if (c >= 2) begin
                n_cmp++;
                if (c <= 6 && {out_valid, sum, cout} !== {1'b1, rx.s, rx.c}) begin
                    n_bad++;
                    $display("FAIL stall_hold cycle %0d: got %b/%h/%b want 1/%h/%b", c, out_valid, sum, cout, rx.s, rx.c);
                end else if (c == 7 && {out_valid, sum, cout} !== {1'b1, ry.s, ry.c}) begin
                    n_bad++;
                    $display("FAIL stall_drain2: got %b/%h/%b want 1/%h/%b", out_valid, sum, cout, ry.s, ry.c);
                end else if (c == 8 && out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_empty: out_valid got %b want 0", out_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            case (c)
                0: begin a = 8'h3C; b = 8'h4D; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1; end
                1: begin in_valid = 1'b0; rst = 1'b1; end
                2: rst = 1'b0;
                default: ;
            endcase
            #1;
            if (c >= 1) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_mid cycle %0d: out_valid got %b want 0", c, out_valid);
                end
            end
        end
    endtask

    task automatic test_random();
        res_t       r;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_sum   = '0;
        logic       prev_cout  = 1'b0;
        int         budget;
        exp_q.delete();
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c < 400) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                a         = 8'($urandom);
                b         = 8'($urandom);
                cin       = 1'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (prev_stall) begin
                n_cmp++;
                if ({out_valid, sum, cout} !== {1'b1, prev_sum, prev_cout}) begin
                    n_bad++;
                    $display("FAIL rand_stable cycle %0d: got %b/%h/%b want 1/%h/%b", c, out_valid, sum, cout, prev_sum, prev_cout);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_spurious cycle %0d: result %h with nothing outstanding", c, sum);
                end else begin
                    r = exp_q.pop_front();
                    if ({sum, cout} !== {r.s, r.c}) begin
                        n_bad++;
                        $display("FAIL rand_result cycle %0d: got %h/%b want %h/%b", c, sum, cout, r.s, r.c);
                    end
`ifdef PIPE_ADDER_OVF_EN
                    n_cmp++;
                    if (ovf !== r.o) begin
                        n_bad++;
                        $display("FAIL rand_ovf cycle %0d: got %b want %b", c, ovf, r.o);
                    end
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model8(a, b, cin));
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            @(negedge clk);
            #1;
            budget++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_drain: %0d results missing, out_valid=%b want 0 missing, 0", exp_q.size(), out_valid);
        end
    endtask

`ifdef PIPE_ADDER_OVF_EN
    task automatic test_ovf();
        out_ready = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            case (c)
                0: begin a = 8'h7F; b = 8'h01; cin = 1'b0; in_valid = 1'b1; end
                1: begin a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1; end
                default: in_valid = 1'b0;
            endcase
            #1;
            if (c == 2) begin
                n_cmp++;
                if ({out_valid, sum, cout, ovf} !== {1'b1, 8'h80, 1'b0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL ovf_pos: got %b/%h/%b/%b want 1/80/0/1", out_valid, sum, cout, ovf);
                end
            end else if (c == 3) begin
                n_cmp++;
                if ({out_valid, sum, cout, ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL ovf_none: got %b/%h/%b/%b want 1/00/1/0", out_valid, sum, cout, ovf);
                end
            end
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_wide();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                w_a = 16'hFFFF; w_b = 16'h0000; w_cin = 1'b1; w_in_valid = 1'b1; w_out_ready = 1'b1;
            end else begin
                w_in_valid = 1'b0;
            end
            #1;
            if (c == 0) begin
                n_cmp++;
                if (w_in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wide_accept: in_ready got %b want 1", w_in_ready);
                end
            end else if (c == 4) begin
                n_cmp++;
                if ({w_out_valid, w_sum, w_cout} !== {1'b1, 16'h0000, 1'b1}) begin
                    n_bad++;
                    $display("FAIL wide_result: got %b/%h/%b want 1/0000/1", w_out_valid, w_sum, w_cout);
                end
`ifdef PIPE_ADDER_OVF_EN
                n_cmp++;
                if (w_ovf !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wide_ovf: got %b want 0", w_ovf);
                end
`endif
            end else begin
                n_cmp++;
                if (w_out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wide_latency cycle %0d: out_valid got %b want 0", c, w_out_valid);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] v;
        logic [2:0] pv;
        int         tot;
        int         sv;
        s_out_ready = 1'b1;
        pv = '0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            v = c[2:0];
            if (c < 8) begin
                {s_a, s_b, s_cin} = v;
                s_in_valid = 1'b1;
            end else begin
                s_in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (c == 0) begin
                if (s_out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_idle: out_valid got %b want 0", s_out_valid);
                end
            end else begin
                tot = int'(pv[2]) + int'(pv[1]) + int'(pv[0]);
                if ({s_out_valid, s_sum, s_cout} !== {1'b1, tot[0], tot[1]}) begin
                    n_bad++;
                    $display("FAIL single_result a=%b b=%b cin=%b: got %b/%b/%b want 1/%b/%b",
                             pv[2], pv[1], pv[0], s_out_valid, s_sum, s_cout, tot[0], tot[1]);
                end
`ifdef PIPE_ADDER_OVF_EN
                // One-bit signed operands hold 0 or -1.
                sv = -int'(pv[2]) - int'(pv[1]) + int'(pv[0]);
                n_cmp++;
                if (s_ovf !== ((sv > 0) || (sv < -1))) begin
                    n_bad++;
                    $display("FAIL single_ovf a=%b b=%b cin=%b: got %b want %b", pv[2], pv[1], pv[0], s_ovf, (sv > 0) || (sv < -1));
                end
`else
                sv = 0;
`endif
            end
            pv = v;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = 1'b0; s_b = 1'b0; s_cin = 1'b0;

        test_reset();
        test_carry_latency();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef PIPE_ADDER_OVF_EN
        test_ovf();
`endif
        test_wide();
        test_single();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
